// File: rtl/attn_row_scale_max.sv
// Softmax pre-stage: scales one score row by SCALE, finds the row maximum and
// subtracts it from every element, LANES elements per cycle, valid/ready out.
module attn_row_scale_max #(
  parameter int                       WIDTH      = 16,
  parameter int                       FRAC_WIDTH = 8,
  parameter int                       COL        = 64,
  parameter int                       LANES      = 8,
  parameter logic signed [WIDTH-1:0]  SCALE      = 16'h0020
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [WIDTH*COL-1:0]   in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH*COL-1:0]   out_data,
  output logic [WIDTH-1:0]       out_max,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int N  = COL / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (COL > 1) ? $clog2(COL) : 1;

  localparam logic signed [WIDTH-1:0]   EL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] P_MAX  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MIN  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0]     D_MAX  = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]     D_MIN  = {2'b11, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SUB  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic signed [WIDTH-1:0]  row_q [COL];
  logic signed [WIDTH-1:0]  max_q;
  logic                     last_q;
  logic                     out_valid_q;
  logic                     out_last_q;

  logic [IW-1:0]            idx_d    [LANES];
  logic signed [WIDTH-1:0]  scaled_d [LANES];
  logic signed [WIDTH-1:0]  diff_d   [LANES];
  logic signed [WIDTH-1:0]  grp_max_d;

  // Full-precision product, floor shift, then clamp to the element range.
  function automatic logic signed [WIDTH-1:0] sat_scale(input logic signed [WIDTH-1:0] x);
    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] se;
    logic signed [2*WIDTH-1:0] p;
    xe = x;
    se = SCALE;
    p  = (xe * se) >>> FRAC_WIDTH;
    if (p > P_MAX)      sat_scale = P_MAX[WIDTH-1:0];
    else if (p < P_MIN) sat_scale = P_MIN[WIDTH-1:0];
    else                sat_scale = p[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] d;
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (d > D_MAX)      sat_sub = D_MAX[WIDTH-1:0];
    else if (d < D_MIN) sat_sub = D_MIN[WIDTH-1:0];
    else                sat_sub = d[WIDTH-1:0];
  endfunction

  assign in_ready  = rst_n && en && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_last  = out_last_q;

  for (genvar g = 0; g < COL; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = row_q[g];
  end

  // Lane datapath for the group selected by the lane counter.
  always_comb begin
    grp_max_d = max_q;
    for (int l = 0; l < LANES; l++) begin
      idx_d[l]    = IW'(int'(cnt_q) * LANES + l);
      scaled_d[l] = sat_scale(row_q[idx_d[l]]);
      diff_d[l]   = sat_sub(row_q[idx_d[l]], max_q);
      if (scaled_d[l] > grp_max_d) grp_max_d = scaled_d[l];
      else                         grp_max_d = grp_max_d;
    end
  end

  // Control FSM, in-place row buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < COL; i++) row_q[i] <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < COL; i++) row_q[i] <= in_data[i*WIDTH +: WIDTH];
            last_q  <= in_last;
            max_q   <= EL_MIN;
            cnt_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          for (int l = 0; l < LANES; l++) row_q[idx_d[l]] <= scaled_d[l];
          max_q <= grp_max_d;
          if (cnt_q == CW'(N-1)) begin
            cnt_q   <= '0;
            state_q <= SUB;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SUB: begin
          for (int l = 0; l < LANES; l++) row_q[idx_d[l]] <= diff_d[l];
          if (cnt_q == CW'(N-1)) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= last_q;
            state_q     <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attn_row_scale_max.sv
// Directed bench for attn_row_scale_max: three instances with different SCALE
// values, hand-computed expected rows, latency, backpressure, enable and reset.
module tb_attn_row_scale_max;

  localparam int DW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                en;
  logic [2:0]          in_valid_v;
  logic [2:0][DW-1:0]  in_data_v;
  logic [2:0]          in_last_v;
  logic [2:0]          in_ready_v;
  logic [2:0]          out_valid_v;
  logic [2:0][DW-1:0]  out_data_v;
  logic [2:0][15:0]    out_max_v;
  logic [2:0]          out_last_v;
  logic [2:0]          out_ready_v;

  int vec_cnt;
  int err_cnt;

  attn_row_scale_max #(.SCALE(16'h0020)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid_v[0]), .in_data(in_data_v[0]), .in_last(in_last_v[0]),
    .in_ready(in_ready_v[0]), .out_valid(out_valid_v[0]), .out_data(out_data_v[0]),
    .out_max(out_max_v[0]), .out_last(out_last_v[0]), .out_ready(out_ready_v[0]));

  attn_row_scale_max #(.SCALE(16'h0800)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid_v[1]), .in_data(in_data_v[1]), .in_last(in_last_v[1]),
    .in_ready(in_ready_v[1]), .out_valid(out_valid_v[1]), .out_data(out_data_v[1]),
    .out_max(out_max_v[1]), .out_last(out_last_v[1]), .out_ready(out_ready_v[1]));

  attn_row_scale_max #(.SCALE(16'h0100)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid_v[2]), .in_data(in_data_v[2]), .in_last(in_last_v[2]),
    .in_ready(in_ready_v[2]), .out_valid(out_valid_v[2]), .out_data(out_data_v[2]),
    .out_max(out_max_v[2]), .out_last(out_last_v[2]), .out_ready(out_ready_v[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] fill_row(input logic [15:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < 64; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp_row();
    logic [DW-1:0] r;
    for (int i = 0; i < 64; i++) r[i*16 +: 16] = 16'(i * 256);
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp_expect();
    logic [DW-1:0] r;
    for (int i = 0; i < 64; i++) r[i*16 +: 16] = 16'((i - 63) * 32);
    return r;
  endfunction

  // Offer a row to instance k, then count cycles from the accept edge to out_valid.
  task automatic send(input int k, input logic [DW-1:0] d, input logic last, output int lat);
    int w;
    in_valid_v[k] = 1'b1;
    in_data_v[k]  = d;
    in_last_v[k]  = last;
    w = 0;
    while (!in_ready_v[k] && w < 50) begin
      step();
      w++;
    end
    step();
    in_valid_v[k] = 1'b0;
    lat = 0;
    while (!out_valid_v[k] && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    vec_cnt++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0 || out_last_v[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl got valid=%b ready=%b last=%b exp 0/0/0",
               out_valid_v[0], in_ready_v[0], out_last_v[0]);
    end
    vec_cnt++;
    if (out_max_v[0] !== 16'h0000 || out_data_v[0] !== '0) begin
      err_cnt++;
      $display("FAIL reset_data got max=%h exp 0000 / data nonzero", out_max_v[0]);
    end
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if (in_ready_v[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_ready got %b exp 1", in_ready_v[0]);
    end
  endtask

  task automatic test_default();
    int lat;
    send(0, fill_row(16'h0100), 1'b0, lat);
    vec_cnt++;
    if (lat !== 16) begin
      err_cnt++;
      $display("FAIL default_latency got %0d exp 16", lat);
    end
    vec_cnt++;
    if (out_max_v[0] !== 16'h0020) begin
      err_cnt++;
      $display("FAIL default_max got %h exp 0020", out_max_v[0]);
    end
    for (int i = 0; i < 64; i++) begin
      vec_cnt++;
      if (out_data_v[0][i*16 +: 16] !== 16'h0000) begin
        err_cnt++;
        $display("FAIL default_elem[%0d] got %h exp 0000", i, out_data_v[0][i*16 +: 16]);
      end
    end
    vec_cnt++;
    if (out_last_v[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL default_last got %b exp 0", out_last_v[0]);
    end
    step();
    vec_cnt++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL default_drop got valid=%b ready=%b exp 0/1", out_valid_v[0], in_ready_v[0]);
    end
  endtask

  task automatic test_ramp();
    int lat;
    logic [DW-1:0] exp_r;
    exp_r = ramp_expect();
    send(0, ramp_row(), 1'b0, lat);
    vec_cnt++;
    if (out_max_v[0] !== 16'h07E0) begin
      err_cnt++;
      $display("FAIL ramp_max got %h exp 07E0", out_max_v[0]);
    end
    for (int i = 0; i < 64; i++) begin
      vec_cnt++;
      if (out_data_v[0][i*16 +: 16] !== exp_r[i*16 +: 16]) begin
        err_cnt++;
        $display("FAIL ramp_elem[%0d] got %h exp %h", i, out_data_v[0][i*16 +: 16], exp_r[i*16 +: 16]);
      end
    end
    vec_cnt++;
    if (out_data_v[0][15:0] !== 16'hF820) begin
      err_cnt++;
      $display("FAIL ramp_elem0 got %h exp F820", out_data_v[0][15:0]);
    end
    step();
  endtask

  // Negative products must round toward minus infinity.
  task automatic test_trunc();
    int lat;
    logic [DW-1:0] d;
    d = fill_row(16'h8000);
    d[15:0]  = 16'hFFFF;
    d[31:16] = 16'h0001;
    send(0, d, 1'b0, lat);
    vec_cnt++;
    if (out_max_v[0] !== 16'h0000) begin
      err_cnt++;
      $display("FAIL trunc_max got %h exp 0000", out_max_v[0]);
    end
    vec_cnt++;
    if (out_data_v[0][15:0] !== 16'hFFFF || out_data_v[0][31:16] !== 16'h0000 ||
        out_data_v[0][47:32] !== 16'hF000) begin
      err_cnt++;
      $display("FAIL trunc_elems got %h %h %h exp FFFF 0000 F000",
               out_data_v[0][15:0], out_data_v[0][31:16], out_data_v[0][47:32]);
    end
    step();
  endtask

  task automatic test_sat_scale();
    int lat;
    logic [DW-1:0] d;
    d = '0;
    d[15:0]  = 16'h7000;
    d[31:16] = 16'h9000;
    send(1, d, 1'b0, lat);
    vec_cnt++;
    if (lat !== 16 || out_max_v[1] !== 16'h7FFF) begin
      err_cnt++;
      $display("FAIL satscale_pos got lat=%0d max=%h exp 16 7FFF", lat, out_max_v[1]);
    end
    vec_cnt++;
    if (out_data_v[1][15:0] !== 16'h0000 || out_data_v[1][31:16] !== 16'h8000 ||
        out_data_v[1][47:32] !== 16'h8001) begin
      err_cnt++;
      $display("FAIL satscale_elems got %h %h %h exp 0000 8000 8001",
               out_data_v[1][15:0], out_data_v[1][31:16], out_data_v[1][47:32]);
    end
    step();
    send(1, fill_row(16'h9000), 1'b0, lat);
    vec_cnt++;
    if (out_max_v[1] !== 16'h8000 || out_data_v[1][15:0] !== 16'h0000) begin
      err_cnt++;
      $display("FAIL satscale_neg got max=%h e0=%h exp 8000 0000", out_max_v[1], out_data_v[1][15:0]);
    end
    step();
  endtask

  task automatic test_sat_sub();
    int lat;
    logic [DW-1:0] d;
    d = '0;
    d[15:0]  = 16'h8000;
    d[31:16] = 16'h7FFF;
    send(2, d, 1'b0, lat);
    vec_cnt++;
    if (out_max_v[2] !== 16'h7FFF) begin
      err_cnt++;
      $display("FAIL satsub_max got %h exp 7FFF", out_max_v[2]);
    end
    vec_cnt++;
    if (out_data_v[2][15:0] !== 16'h8000 || out_data_v[2][31:16] !== 16'h0000 ||
        out_data_v[2][47:32] !== 16'h8001) begin
      err_cnt++;
      $display("FAIL satsub_elems got %h %h %h exp 8000 0000 8001",
               out_data_v[2][15:0], out_data_v[2][31:16], out_data_v[2][47:32]);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [DW-1:0] exp_r;
    exp_r = ramp_expect();
    out_ready_v[0] = 1'b0;
    send(0, ramp_row(), 1'b0, lat);
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = fill_row(16'h0100);
    in_last_v[0]  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vec_cnt++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || out_last_v[0] !== 1'b0 ||
          out_max_v[0] !== 16'h07E0 || out_data_v[0] !== exp_r) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d] got valid=%b ready=%b last=%b max=%h exp 1 0 0 07E0",
                 c, out_valid_v[0], in_ready_v[0], out_last_v[0], out_max_v[0]);
      end
      step();
    end
    out_ready_v[0] = 1'b1;
    step();
    vec_cnt++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_idle got valid=%b ready=%b exp 0 1", out_valid_v[0], in_ready_v[0]);
    end
    step();
    in_valid_v[0] = 1'b0;
    lat = 0;
    while (!out_valid_v[0] && lat < 100) begin
      step();
      lat++;
    end
    vec_cnt++;
    if (lat !== 16 || out_last_v[0] !== 1'b1 || out_max_v[0] !== 16'h0020) begin
      err_cnt++;
      $display("FAIL bp_second got lat=%0d last=%b max=%h exp 16 1 0020", lat, out_last_v[0], out_max_v[0]);
    end
    step();
    vec_cnt++;
    if (out_last_v[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_last_clear got %b exp 0", out_last_v[0]);
    end
    in_last_v[0] = 1'b0;
  endtask

  task automatic test_en_pause();
    int lat;
    logic [DW-1:0] exp_r;
    exp_r = ramp_expect();
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = ramp_row();
    step();
    in_valid_v[0] = 1'b0;
    lat = 0;
    repeat (10) begin
      step();
      lat++;
    end
    en = 1'b0;
    repeat (3) begin
      step();
      lat++;
    end
    en = 1'b1;
    while (!out_valid_v[0] && lat < 100) begin
      step();
      lat++;
    end
    vec_cnt++;
    if (lat !== 19) begin
      err_cnt++;
      $display("FAIL en_latency got %0d exp 19", lat);
    end
    vec_cnt++;
    if (out_max_v[0] !== 16'h07E0 || out_data_v[0] !== exp_r) begin
      err_cnt++;
      $display("FAIL en_result got max=%h e0=%h exp 07E0 F820", out_max_v[0], out_data_v[0][15:0]);
    end
    en = 1'b0;
    step();
    vec_cnt++;
    if (out_valid_v[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL en_hold_handshake got valid=%b exp 1", out_valid_v[0]);
    end
    en = 1'b1;
    step();
    vec_cnt++;
    if (out_valid_v[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL en_release got valid=%b exp 0", out_valid_v[0]);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = ramp_row();
    step();
    in_valid_v[0] = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_scan got valid=%b ready=%b exp 0 0", out_valid_v[0], in_ready_v[0]);
    end
    step();
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if (in_ready_v[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL abort_ready got %b exp 1", in_ready_v[0]);
    end
    seen = 0;
    repeat (20) begin
      step();
      if (out_valid_v[0]) seen++;
    end
    vec_cnt++;
    if (seen !== 0) begin
      err_cnt++;
      $display("FAIL abort_no_output got %0d valid cycles exp 0", seen);
    end
    out_ready_v[0] = 1'b0;
    send(0, ramp_row(), 1'b0, lat);
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid_v[0] !== 1'b0 || out_max_v[0] !== 16'h0000 || out_data_v[0] !== '0) begin
      err_cnt++;
      $display("FAIL abort_hold got valid=%b max=%h exp 0 0000", out_valid_v[0], out_max_v[0]);
    end
    step();
    rst_n = 1'b1;
    out_ready_v[0] = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    en          = 1'b1;
    in_valid_v  = '0;
    in_data_v   = '0;
    in_last_v   = '0;
    out_ready_v = '1;
    vec_cnt     = 0;
    err_cnt     = 0;
    test_reset();
    test_default();
    test_ramp();
    test_trunc();
    test_sat_scale();
    test_sat_sub();
    test_backpressure();
    test_en_pause();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
